// File: rtl/ili9341_controller.sv
// ILI9341 SPI display controller.
// Sends the power-up command sequence, programs a full-screen window, then
// streams RGB565 pixels (one every 32 clocks) until upstream flags frame_done.
module ili9341_controller #(
    parameter int WIDTH         = 240,
    parameter int HEIGHT        = 240,
    parameter int SWRESET_DELAY = 300000,
    parameter int SLPOUT_DELAY  = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] input_data,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_dc,
    output logic        data_clk
);

    typedef enum logic [2:0] {INIT, DELAY, WINDOW, STREAM, WAIT_FRAME} state_t;

    // One counter serves byte bits, pixel bits and delays, so it must hold
    // the longest delay as well as the 32-cycle pixel period.
    localparam int DLY_MAX = (SLPOUT_DELAY > SWRESET_DELAY) ? SLPOUT_DELAY : SWRESET_DELAY;
    localparam int CNT_W   = (DLY_MAX > 32) ? $clog2(DLY_MAX + 1) : 6;

    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(16);  // gap cycle after 16 bit cycles
    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(31);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SWRESET_DELAY - 1);
    localparam logic [CNT_W-1:0] SLP_LAST  = CNT_W'(SLPOUT_DELAY - 1);

    // Byte table positions: 0..6 power-up, 7..17 window setup.
    localparam logic [4:0] IDX_SWRESET  = 5'd0;
    localparam logic [4:0] IDX_SLPOUT   = 5'd1;
    localparam logic [4:0] IDX_INIT_END = 5'd6;
    localparam logic [4:0] IDX_WIN_BEG  = 5'd7;
    localparam logic [4:0] IDX_WIN_END  = 5'd17;

    localparam logic [15:0] W_M1 = 16'(WIDTH - 1);
    localparam logic [15:0] H_M1 = 16'(HEIGHT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         idx_q, idx_d;
    logic [15:0]        sh_q, sh_d;
    logic               data_clk_q, data_clk_d;
    logic               run_q, run_d;     // low for the first cycle out of reset
    logic               rom_dc;
    logic [7:0]         rom_byte;
    logic [CNT_W-1:0]   pix_next;

    // Command/parameter table: dc flag and byte for the current position.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rom_dc   = 1'b0;
        rom_byte = 8'h00;
        case (idx_q)
            5'd0:  rom_byte = 8'h01;
            5'd1:  rom_byte = 8'h11;
            5'd2:  rom_byte = 8'h3A;
            5'd3:  begin rom_dc = 1'b1; rom_byte = 8'h55; end
            5'd4:  rom_byte = 8'h36;
            5'd5:  begin rom_dc = 1'b1; rom_byte = 8'h08; end
            5'd6:  rom_byte = 8'h29;
            5'd7:  rom_byte = 8'h2A;
            5'd8,
            5'd9:  rom_dc = 1'b1;
            5'd10: begin rom_dc = 1'b1; rom_byte = W_M1[15:8]; end
            5'd11: begin rom_dc = 1'b1; rom_byte = W_M1[7:0]; end
            5'd12: rom_byte = 8'h2B;
            5'd13,
            5'd14: rom_dc = 1'b1;
            5'd15: begin rom_dc = 1'b1; rom_byte = H_M1[15:8]; end
            5'd16: begin rom_dc = 1'b1; rom_byte = H_M1[7:0]; end
            5'd17: rom_byte = 8'h2C;
            default: ;
        endcase
    end

    // State register: all state, counters and shift register with sync reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            idx_q      <= IDX_SWRESET;
            sh_q       <= '0;
            data_clk_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            data_clk_q <= data_clk_d;
            run_q      <= run_d;
        end
    end

    // Next-state logic: byte sequencing, delays and the 32-cycle pixel clock.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        run_d      = 1'b1;
        pix_next   = (cnt_q == PIX_LAST) ? '0 : cnt_q + CNT_W'(1);
        data_clk_d = run_q && (state_q == STREAM || state_q == WAIT_FRAME) && (cnt_q == '0);
        if (run_q) begin
            case (state_q)
                INIT, WINDOW: begin
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 5'd1;
                        if (idx_q == IDX_SWRESET || idx_q == IDX_SLPOUT) state_d = DELAY;
                        else if (idx_q == IDX_INIT_END)                  state_d = WINDOW;
                        else if (idx_q == IDX_WIN_END)                   state_d = STREAM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DELAY: begin
                    // idx has already moved past the command that started the delay
                    if (cnt_q == ((idx_q == IDX_SLPOUT) ? SW_LAST : SLP_LAST)) begin
                        cnt_d   = '0;
                        state_d = INIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STREAM: begin
                    cnt_d = pix_next;
                    if (cnt_q == '0) begin
                        if (frame_done) state_d = WAIT_FRAME;
                        else            sh_d    = input_data;
                    end
                end
                WAIT_FRAME: begin
                    if (!frame_done) begin
                        state_d = WINDOW;
                        idx_d   = IDX_WIN_BEG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = pix_next;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    // Output decode: SPI pins from state and counter; idle values otherwise.
    always_comb begin
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        spi_dc   = 1'b0;
        data_clk = data_clk_q;
        if (run_q) begin
            case (state_q)
                INIT, WINDOW: begin
                    spi_dc = rom_dc;
                    if (cnt_q < BYTE_LAST) begin
                        spi_cs   = 1'b0;
                        spi_sck  = cnt_q[0];
                        spi_mosi = rom_byte[3'd7 - cnt_q[3:1]];
                    end
                end
                STREAM: begin
                    // A boundary with frame_done set ends the frame immediately.
                    if (!(cnt_q == '0 && frame_done)) begin
                        spi_cs   = 1'b0;
                        spi_dc   = 1'b1;
                        spi_sck  = cnt_q[0];
                        spi_mosi = (cnt_q == '0) ? input_data[15] : sh_q[4'd15 - cnt_q[4:1]];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_controller.sv
// Self-checking bench for ili9341_controller: decodes the SPI bytes of the
// power-up and window sequences, checks pixel streaming, end of frame,
// frame restart and mid-pixel reset.
module tb_ili9341_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done = 1'b0;
    logic [15:0] input_data = 16'h0000;
    logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        int         gmin;
        int         gmax;
    } byte_vec_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] bits;
    } pix_vec_t;

    byte_vec_t bv [18];
    pix_vec_t  pv [4];

    logic mosi_l [0:255];
    logic sck_l  [0:255];
    logic cs_l   [0:255];
    logic dc_l   [0:255];
    logic dclk_l [0:255];

    ili9341_controller #(
        .WIDTH(240), .HEIGHT(240), .SWRESET_DELAY(4), .SLPOUT_DELAY(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .input_data(input_data),
        .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs),
        .spi_dc(spi_dc), .data_clk(data_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decode one SPI byte starting at the current negedge; returns at the
    // negedge following its 16th cycle.
    task automatic get_byte(output logic dc, output logic [7:0] b, output int gap,
                            output logic tim_ok);
        gap    = 0;
        tim_ok = 1'b1;
        b      = 8'h00;
        while (spi_cs !== 1'b0 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        dc = spi_dc;
        for (int k = 0; k < 16; k++) begin
            if (spi_cs !== 1'b0 || spi_sck !== ((k % 2) == 1) || spi_dc !== dc) tim_ok = 1'b0;
            if (k % 2 == 0) b[3'(7 - k / 2)] = spi_mosi;
            else if (spi_mosi !== b[3'(7 - k / 2)]) tim_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_byte(input int i, input int gmin, input int gmax);
        logic       dc;
        logic [7:0] b;
        int         gap;
        logic       tim_ok;
        get_byte(dc, b, gap, tim_ok);
        check($sformatf("byte[%0d] data", i), {24'h0, b}, {24'h0, bv[i].data});
        check($sformatf("byte[%0d] dc", i), {31'h0, dc}, {31'h0, bv[i].dc});
        check($sformatf("byte[%0d] gap=%0d in [%0d,%0d]", i, gap, gmin, gmax),
              {31'h0, (gap >= gmin && gap <= gmax)}, 32'h1);
        check($sformatf("byte[%0d] bit timing", i), {31'h0, tim_ok}, 32'h1);
    endtask

    task automatic sample(input int c);
        mosi_l[c] = spi_mosi;
        sck_l[c]  = spi_sck;
        cs_l[c]   = spi_cs;
        dc_l[c]   = spi_dc;
        dclk_l[c] = data_clk;
    endtask

    task automatic check_pixel(input int base, input int p);
        logic [15:0] bits;
        int          unstable;
        unstable = 0;
        for (int j = 0; j < 16; j++) begin
            bits[15 - j] = mosi_l[base + 2 * j];
            if (mosi_l[base + 2 * j + 1] !== mosi_l[base + 2 * j]) unstable++;
        end
        check($sformatf("pixel@%0d bits", base), {16'h0, bits}, {16'h0, pv[p].bits});
        check($sformatf("pixel@%0d mosi unstable while sck=1", base), unstable, 0);
    endtask

    task automatic check_active(input int from, input int to);
        int bad;
        bad = 0;
        for (int c = from; c <= to; c++)
            if (cs_l[c] !== 1'b0 || dc_l[c] !== 1'b1 || sck_l[c] !== ((c % 2) == 1)) bad++;
        check($sformatf("stream cs/dc/sck %0d..%0d bad cycles", from, to), bad, 0);
    endtask

    task automatic check_idle(input int from, input int to);
        int bad;
        bad = 0;
        for (int c = from; c <= to; c++)
            if (cs_l[c] !== 1'b1 || sck_l[c] !== 1'b0 || mosi_l[c] !== 1'b0) bad++;
        check($sformatf("wait_frame idle %0d..%0d bad cycles", from, to), bad, 0);
    endtask

    // data_clk follows every boundary by one cycle: cycles 1, 33, 65, ...
    task automatic check_dclk(input int n);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++)
            if (dclk_l[c] !== ((c % 32) == 1)) bad++;
        check($sformatf("data_clk pattern 0..%0d bad cycles", n - 1), bad, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " cs"},       {31'h0, spi_cs},   32'h1);
        check({name, " sck"},      {31'h0, spi_sck},  32'h0);
        check({name, " mosi"},     {31'h0, spi_mosi}, 32'h0);
        check({name, " dc"},       {31'h0, spi_dc},   32'h0);
        check({name, " data_clk"}, {31'h0, data_clk}, 32'h0);
    endtask

    initial begin
        bv[0]  = '{1'b0, 8'h01, 0, 200};
        bv[1]  = '{1'b0, 8'h11, 4, 8};
        bv[2]  = '{1'b0, 8'h3A, 4, 8};
        bv[3]  = '{1'b1, 8'h55, 1, 1};
        bv[4]  = '{1'b0, 8'h36, 1, 1};
        bv[5]  = '{1'b1, 8'h08, 1, 1};
        bv[6]  = '{1'b0, 8'h29, 1, 1};
        bv[7]  = '{1'b0, 8'h2A, 1, 1};
        bv[8]  = '{1'b1, 8'h00, 1, 1};
        bv[9]  = '{1'b1, 8'h00, 1, 1};
        bv[10] = '{1'b1, 8'h00, 1, 1};
        bv[11] = '{1'b1, 8'hEF, 1, 1};
        bv[12] = '{1'b0, 8'h2B, 1, 1};
        bv[13] = '{1'b1, 8'h00, 1, 1};
        bv[14] = '{1'b1, 8'h00, 1, 1};
        bv[15] = '{1'b1, 8'h00, 1, 1};
        bv[16] = '{1'b1, 8'hEF, 1, 1};
        bv[17] = '{1'b0, 8'h2C, 1, 1};

        pv[0] = '{16'hF81F, 16'b1111100000011111};
        pv[1] = '{16'h07E0, 16'b0000011111100000};
        pv[2] = '{16'hA5C3, 16'b1010010111000011};
        pv[3] = '{16'h1234, 16'b0001001000110100};

        // Reset held for three edges: outputs must sit at their idle values.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        input_data = pv[0].din;
        rst = 1'b0;

        // Power-up and window byte sequence.
        for (int i = 0; i < 18; i++) run_byte(i, bv[i].gmin, bv[i].gmax);

        // Stream: two pixels, a third with frame_done raised 5 cycles in,
        // then two pulse periods of WAIT_FRAME.
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1)  input_data = pv[1].din;
            if (c == 33) input_data = pv[2].din;
            if (c == 69) frame_done = 1'b1;
        end
        check_pixel(0, 0);
        check_pixel(32, 1);
        check_pixel(64, 2);
        check_active(0, 95);
        check_idle(96, 159);
        check_dclk(160);

        // Drop frame_done: window is re-sent, then streaming resumes.
        frame_done = 1'b0;
        input_data = pv[3].din;
        run_byte(7, 1, 2);
        for (int i = 8; i < 18; i++) run_byte(i, bv[i].gmin, bv[i].gmax);
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            sample(c);
        end
        check_pixel(0, 3);
        check_active(0, 41);
        check_dclk(42);

        // One-cycle reset 10 cycles into a pixel, then restart from 0x01.
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-pixel reset");
        rst = 1'b0;
        run_byte(0, 1, 2);
        run_byte(1, bv[1].gmin, bv[1].gmax);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ili9341_controller.md
ILI9341_CONTROLLER -- requirements
Module: ili9341_controller

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset.
REQ-002 The block SHALL have these parameters:
- WIDTH, 240: window width in pixels.
- HEIGHT, 240: window height in pixels.
- SWRESET_DELAY, 300000: clk cycles waited after command 0x01.
- SLPOUT_DELAY, 3000000: clk cycles waited after command 0x11.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- frame_done  in  1  upstream flag: current frame fully supplied.
- input_data  in  16  RGB565 pixel to send next.
- spi_mosi  out  1  serial data, MSB first.
- spi_sck  out  1  serial clock.
- spi_cs  out  1  chip select, active low.
- spi_dc  out  1  0 = command byte, 1 = parameter/pixel data.
- data_clk  out  1  one-cycle pixel-request strobe.

Function
REQ-004 The block SHALL have these states: INIT, DELAY, WINDOW, STREAM, WAIT_FRAME.
REQ-005 A byte transfer SHALL take 16 cycles with spi_cs=0, structured as follows:
- for bit i (i=7..0), cycle 2(7-i) has spi_sck=0 and spi_mosi=bit i;
- the following cycle has spi_sck=1 and spi_mosi held.
REQ-006 In INIT and WINDOW, every byte SHALL be followed by exactly 1 cycle with spi_cs=1, spi_sck=0.
REQ-007 INIT SHALL send this fixed sequence, with dc=0 for commands and dc=1 for parameters:
- 0x01, then DELAY for SWRESET_DELAY cycles;
- 0x11, then DELAY for SLPOUT_DELAY cycles;
- 0x3A, 0x55; 0x36, 0x08; 0x29;
- then enter WINDOW.
REQ-008 During DELAY the outputs SHALL hold spi_cs=1, spi_sck=0, spi_mosi=0.
REQ-009 WINDOW SHALL send the following, then enter STREAM:
- 0x2A, 0x00, 0x00, (WIDTH-1)[15:8], (WIDTH-1)[7:0];
- 0x2B, 0x00, 0x00, (HEIGHT-1)[15:8], (HEIGHT-1)[7:0];
- 0x2C.
- With defaults, the last parameter of each group is 0xEF.
REQ-010 In STREAM, each pixel SHALL occupy 32 cycles:
- spi_cs=0 and spi_dc=1 continuously;
- 16 bits sent MSB first with the REQ-005 bit timing;
- no gap between consecutive pixels.
REQ-011 The pixel boundary SHALL be the first cycle of STREAM and every 32nd cycle thereafter.
- At a boundary with frame_done=0, input_data SHALL be latched into the shift register and transmitted starting that cycle.
REQ-012 data_clk SHALL be 1 for exactly the one cycle after each pixel boundary, and 0 otherwise.
REQ-013 At a pixel boundary with frame_done=1:
- no latch occurs;
- spi_cs goes 1 in that cycle;
- the state moves to WAIT_FRAME.
- A pixel already in progress always completes; frame_done is ignored mid-pixel.
REQ-014 In WAIT_FRAME:
- spi_cs=1, spi_sck=0, spi_mosi=0;
- data_clk still pulses once every 32 cycles, so the upstream can clear frame_done;
- on the first cycle frame_done=0 is sampled, the state moves to WAIT_FRAME→WINDOW, re-sending the full window sequence, then STREAM.
REQ-015 The block SHALL NOT count pixels; frame length is governed only by frame_done.
REQ-016 Delay and bit counters SHALL be sized to hold SLPOUT_DELAY without wrap.

Reset
REQ-017 While rst=1, all outputs SHALL be held as follows:
- spi_cs=1, spi_sck=0, spi_mosi=0, spi_dc=0, data_clk=0;
- state=INIT at the first byte;
- counters and shift register cleared.
REQ-018 When rst is asserted at any point, including mid-byte, mid-delay or mid-pixel, the block SHALL abort the transfer on the next edge and restart INIT from 0x01 after release.

Verification
REQ-019 Reset release with SWRESET_DELAY=4 and SLPOUT_DELAY=4 -> the SPI decode SHALL be, in order:
- cmd 01, gap ≥4 cycles;
- cmd 11, gap ≥4 cycles;
- 3A/55, 36/08, 29;
- 2A/00/00/00/EF, 2B/00/00/00/EF, 2C.
- dc=0 exactly on the command bytes.
REQ-020 STREAM with frame_done=0 and input_data=0xF81F then 0x07E0 -> the bench SHALL see:
- mosi bits 1111100000011111 then 0000011111100000;
- 64 cycles total, cs low throughout;
- data_clk high once at cycle 1 and once at cycle 33.
REQ-021 Raise frame_done 5 cycles into a pixel -> that pixel completes (32 cycles total), then:
- cs=1 at the boundary, with no further mosi activity;
- data_clk keeps pulsing every 32 cycles.
REQ-022 From WAIT_FRAME, drop frame_done -> the window sequence 2A..2C is re-sent, then streaming resumes, and the first latched pixel equals input_data at the first STREAM boundary.
REQ-023 Assert rst for 1 cycle in the middle of a pixel -> on the next edge all outputs take reset values, and after release the sequence restarts with cmd 0x01.
REQ-024 Each byte SHALL be 16 cycles plus a 1-cycle cs gap in INIT/WINDOW, with sck=0 on even cycles and 1 on odd cycles, and mosi stable while sck=1.
